// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Holds the FSM state encoding used by serial_adder.
package serial_adder_pkg;

    // Controller states; encodings are fixed so waveforms stay readable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell.
// Ports:
//   a, b, ci : operand bits and carry-in
//   s        : sum bit
//   co       : carry-out
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: computes a + b + ci one bit per clock, LSB first,
// using a single full-adder cell and a carry flip-flop.
// Ports:
//   clock        : system clock, rising edge active
//   reset        : synchronous, active-high reset (wins over everything)
//   start        : request to load operands and begin (honoured in IDLE only)
//   a, b, ci     : operands, sampled on the accepting edge only
//   busy         : high while bits are being processed
//   done         : one-cycle pulse when s/co hold the final result
//   s, co        : registered sum and carry-out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         co
);

    localparam int             CW   = $clog2(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t          state_r;
    state_t          state_next_s;
    logic            accept_s;
    logic            last_bit_s;
    logic [N-1:0]    a_sr_r;
    logic [N-1:0]    b_sr_r;
    logic [N-1:0]    s_sr_r;
    logic            carry_r;
    logic            co_r;
    logic [CW-1:0]   count_r;
    logic            fa_sum_s;
    logic            fa_carry_s;

    // The one and only adder cell, fed from the LSBs of the operand shifters.
    fa u_fa (
        .a  (a_sr_r[0]),
        .b  (b_sr_r[0]),
        .ci (carry_r),
        .s  (fa_sum_s),
        .co (fa_carry_s)
    );

    // Next-state decode; start is only looked at while idle.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_bit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == LAST) begin
                    state_next_s = ST_DONE;
                    last_bit_s   = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next_s == ST_RUN);
            done <= (state_next_s == ST_DONE);
        end
    end

    // Datapath: operand load, serial add, result shift-in.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_sr_r  <= {N{1'b0}};
            b_sr_r  <= {N{1'b0}};
            s_sr_r  <= {N{1'b0}};
            carry_r <= 1'b0;
            co_r    <= 1'b0;
            count_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        carry_r <= ci;
                        count_r <= {CW{1'b0}};
                        s_sr_r  <= {N{1'b0}};
                        co_r    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the MSB so that after N shifts bit 0
                    // of the result sits at s_sr_r[0].
                    s_sr_r  <= {fa_sum_s, s_sr_r[N-1:1]};
                    a_sr_r  <= {1'b0, a_sr_r[N-1:1]};
                    b_sr_r  <= {1'b0, b_sr_r[N-1:1]};
                    carry_r <= fa_carry_s;
                    if (last_bit_s) begin
                        // Carry out of the MSB is the result carry; the counter
                        // is left at its final value rather than wrapping.
                        co_r <= fa_carry_s;
                    end else begin
                        count_r <= count_r + CW'(1'b1);
                    end
                end
                default: begin
                    // DONE: hold the result for the consumer.
                end
            endcase
        end
    end

    assign s  = s_sr_r;
    assign co = co_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an N=8 instance for directed and random
// operations, plus an N=2 instance swept exhaustively. Expected results come
// from plain integer addition of the operands.
module tb_serial_adder;

    logic       clock = 1'b0;
    logic       reset;
    logic       start8, ci8, busy8, done8, co8;
    logic [7:0] a8, b8, s8;
    logic       start2, ci2, busy2, done2, co2;
    logic [1:0] a2, b2, s2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    serial_adder #(.N(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8)
    );

    serial_adder #(.N(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .s(s2), .co(co2)
    );

    // Runs one N=8 addition and reports what was observed. Optionally pulses
    // start with different operands while the addition is running.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                        input bit inject, output int lat, output logic [8:0] res,
                        output bit busy_ok, output bit pulse_ok);
        logic busy_at_done;
        a8 = ta; b8 = tb; ci8 = tci; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        busy_at_done = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (inject && k == 3) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; ci8 = 1'b1;
            end
            if (inject && k == 5) start8 = 1'b0;
            @(posedge clock); #1;
            if (done8) begin
                lat = k;
                busy_at_done = busy8;
                break;
            end
            if (!busy8) busy_ok = 1'b0;
        end
        res = {co8, s8};
        @(posedge clock); #1;
        pulse_ok = !busy_at_done && !done8 && !busy8 && ({co8, s8} == res);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
        start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; ci2 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++;
        if ({busy8, done8, co8, s8} !== 11'h000) begin
            errors++;
            $display("FAIL reset_n8: busy=%b done=%b co=%b s=%h, required all 0", busy8, done8, co8, s8);
        end
        checks++;
        if ({busy2, done2, co2, s2} !== 5'h00) begin
            errors++;
            $display("FAIL reset_n2: busy=%b done=%b co=%b s=%h, required all 0", busy2, done2, co2, s2);
        end
    endtask

    task automatic test_directed;
        logic [7:0] va [3] = '{8'hFF, 8'hA5, 8'h7F};
        logic [7:0] vb [3] = '{8'h01, 8'h5A, 8'h01};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        int lat; logic [8:0] res, exp; bit bok, pok;
        for (int i = 0; i < 3; i++) begin
            exp = 9'(va[i]) + 9'(vb[i]) + 9'(vc[i]);
            run8(va[i], vb[i], vc[i], (i == 2), lat, res, bok, pok);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL directed_%0d result: {co,s}=%h, required %h", i, res, exp);
            end
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL directed_%0d latency: done after %0d edges, required 8", i, lat);
            end
            checks++;
            if (!bok || !pok) begin
                errors++;
                $display("FAIL directed_%0d handshake: busy_ok=%0b pulse_ok=%0b, required 1 1", i, bok, pok);
            end
        end
    endtask

    task automatic test_random;
        int lat; logic [8:0] res, exp; bit bok, pok;
        logic [7:0] ta, tb; logic tc;
        for (int i = 0; i < 20; i++) begin
            ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
            exp = 9'(ta) + 9'(tb) + 9'(tc);
            run8(ta, tb, tc, 1'b0, lat, res, bok, pok);
            checks++;
            if (res !== exp || lat != 8 || !bok || !pok) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h ci=%b got %h lat=%0d bok=%0b pok=%0b, required %h lat=8",
                         i, ta, tb, tc, res, lat, bok, pok, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int lat; logic [8:0] res, exp; bit bok, pok, seen;
        a8 = 8'hC3; b8 = 8'h3C; ci8 = 1'b1; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if ({busy8, done8, co8, s8} !== 11'h000) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b co=%b s=%h, required all 0", busy8, done8, co8, s8);
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (done8 || busy8) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: activity after abort=1, required 0");
        end
        exp = 9'(8'h96) + 9'(8'h4B);
        run8(8'h96, 8'h4B, 1'b0, 1'b0, lat, res, bok, pok);
        checks++;
        if (res !== exp || lat != 8 || !bok || !pok) begin
            errors++;
            $display("FAIL abort_restart: got %h lat=%0d, required %h lat=8", res, lat, exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] qa [$]; logic [7:0] qb [$]; logic qc [$];
        logic [8:0] exp; int gap, prev;
        for (int i = 0; i < 3; i++) begin
            qa.push_back(8'($urandom)); qb.push_back(8'($urandom)); qc.push_back(1'($urandom));
        end
        a8 = qa[0]; b8 = qb[0]; ci8 = qc[0]; start8 = 1'b1;
        @(posedge clock); #1;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            gap = -1;
            for (int k = 1; k <= 16; k++) begin
                @(posedge clock); #1;
                if (done8) begin gap = k; break; end
            end
            exp = 9'(qa[i]) + 9'(qb[i]) + 9'(qc[i]);
            checks++;
            if ({co8, s8} !== exp || gap != ((i == 0) ? 8 : 10)) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %h gap=%0d, required %h gap=%0d",
                         i, {co8, s8}, gap, exp, (i == 0) ? 8 : 10);
            end
            if (i < 2) begin
                a8 = qa[i+1]; b8 = qb[i+1]; ci8 = qc[i+1];
            end else begin
                start8 = 1'b0;
            end
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_n2_exhaustive;
        int lat; logic [2:0] exp; int bad;
        bad = 0;
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a2 = 2'(ia); b2 = 2'(ib); ci2 = 1'(ic); start2 = 1'b1;
                    exp = 3'(ia + ib + ic);
                    @(posedge clock); #1;
                    start2 = 1'b0;
                    lat = -1;
                    for (int k = 1; k <= 6; k++) begin
                        @(posedge clock); #1;
                        if (done2) begin lat = k; break; end
                    end
                    checks++;
                    if ({co2, s2} !== exp || lat != 2) begin
                        errors++;
                        $display("FAIL n2_a%0d_b%0d_c%0d: got %h lat=%0d, required %h lat=2",
                                 ia, ib, ic, {co2, s2}, lat, exp);
                    end
                    @(posedge clock); #1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        test_n2_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
